// File: rtl/avalon_st_demultiplexer.sv
// avalon_st_demultiplexer
//   Steers whole Avalon-ST packets from one merged input to one of two
//   outputs. The channel field of the start-of-packet beat picks the output
//   (channel 0 -> output one, any other -> output two). Beats that arrive
//   outside a packet (no sop while idle) are consumed and discarded.
//   Each output has a single register stage (1-cycle latency, full rate).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   avsi_*              input stream (channel/data/valid/sop/eop/empty, ready out)
//   avso_one_*          output one stream (ready in)
//   avso_two_*          output two stream (ready in)
//   pkt_cnt_one/two     completed packet counters   (only with DEMUX_PKT_CNT_EN)
//   drop_cnt            dropped beat counter         (only with DEMUX_PKT_CNT_EN)
//
// Build option:
//   DEMUX_PKT_CNT_EN    adds the three 16-bit wrapping statistics counters.

module avalon_st_demultiplexer #(
    parameter int data_width    = 128,
    parameter int empty_width   = 2,
    parameter int channel_width = 1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [channel_width-1:0] avsi_channel,
    input  logic [data_width-1:0]    avsi_data,
    input  logic                     avsi_valid,
    input  logic                     avsi_sop,
    input  logic                     avsi_eop,
    input  logic [empty_width-1:0]   avsi_empty,
    output logic                     avsi_ready,

    output logic [channel_width-1:0] avso_one_channel,
    output logic [data_width-1:0]    avso_one_data,
    output logic                     avso_one_sop,
    output logic                     avso_one_eop,
    output logic [empty_width-1:0]   avso_one_empty,
    output logic                     avso_one_valid,
    input  logic                     avso_one_ready,

    output logic [channel_width-1:0] avso_two_channel,
    output logic [data_width-1:0]    avso_two_data,
    output logic                     avso_two_sop,
    output logic                     avso_two_eop,
    output logic [empty_width-1:0]   avso_two_empty,
    output logic                     avso_two_valid,
    input  logic                     avso_two_ready
`ifdef DEMUX_PKT_CNT_EN
    ,
    output logic [15:0]              pkt_cnt_one,
    output logic [15:0]              pkt_cnt_two,
    output logic [15:0]              drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ROUTE_ONE = 2'd1,
        ROUTE_TWO = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic slot_one_free;
    logic slot_two_free;
    logic accept;
    logic load_one;
    logic load_two;

    assign slot_one_free = !avso_one_valid | avso_one_ready;
    assign slot_two_free = !avso_two_valid | avso_two_ready;

    // In IDLE the destination is not known until the sop beat is seen, so
    // both slots must be free; ready never looks at valid or channel.
    always_comb begin
        avsi_ready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:      avsi_ready = slot_one_free & slot_two_free;
                ROUTE_ONE: avsi_ready = slot_one_free;
                ROUTE_TWO: avsi_ready = slot_two_free;
                default:   avsi_ready = 1'b0;
            endcase
        end
    end

    assign accept = avsi_valid & avsi_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_one   = 1'b0;
        load_two   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && avsi_sop) begin
                    if (avsi_channel == '0) begin
                        load_one = 1'b1;
                        if (!avsi_eop) next_state = ROUTE_ONE;
                    end else begin
                        load_two = 1'b1;
                        if (!avsi_eop) next_state = ROUTE_TWO;
                    end
                end
            end
            ROUTE_ONE: begin
                // A stray sop mid-packet is forwarded as-is; only eop ends the packet.
                if (accept) begin
                    load_one = 1'b1;
                    if (avsi_eop) next_state = IDLE;
                end
            end
            ROUTE_TWO: begin
                if (accept) begin
                    load_two = 1'b1;
                    if (avsi_eop) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Load has priority over drain so back-to-back beats keep valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avso_one_channel <= '0;
            avso_one_data    <= '0;
            avso_one_sop     <= 1'b0;
            avso_one_eop     <= 1'b0;
            avso_one_empty   <= '0;
            avso_one_valid   <= 1'b0;
        end else if (load_one) begin
            avso_one_channel <= avsi_channel;
            avso_one_data    <= avsi_data;
            avso_one_sop     <= avsi_sop;
            avso_one_eop     <= avsi_eop;
            avso_one_empty   <= avsi_empty;
            avso_one_valid   <= 1'b1;
        end else if (avso_one_ready) begin
            avso_one_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avso_two_channel <= '0;
            avso_two_data    <= '0;
            avso_two_sop     <= 1'b0;
            avso_two_eop     <= 1'b0;
            avso_two_empty   <= '0;
            avso_two_valid   <= 1'b0;
        end else if (load_two) begin
            avso_two_channel <= avsi_channel;
            avso_two_data    <= avsi_data;
            avso_two_sop     <= avsi_sop;
            avso_two_eop     <= avsi_eop;
            avso_two_empty   <= avsi_empty;
            avso_two_valid   <= 1'b1;
        end else if (avso_two_ready) begin
            avso_two_valid   <= 1'b0;
        end
    end

`ifdef DEMUX_PKT_CNT_EN
    logic drop;
    assign drop = accept & (state == IDLE) & !avsi_sop;

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_one <= '0;
            pkt_cnt_two <= '0;
            drop_cnt    <= '0;
        end else begin
            if (avso_one_valid && avso_one_ready && avso_one_eop) pkt_cnt_one <= pkt_cnt_one + 16'd1;
            if (avso_two_valid && avso_two_ready && avso_two_eop) pkt_cnt_two <= pkt_cnt_two + 16'd1;
            if (drop) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_st_demultiplexer.sv
module tb_avalon_st_demultiplexer;

    localparam int DW = 128;
    localparam int EW = 2;
    localparam int CW = 1;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] avsi_channel = '0;
    logic [DW-1:0] avsi_data = '0;
    logic          avsi_valid = 1'b0;
    logic          avsi_sop = 1'b0;
    logic          avsi_eop = 1'b0;
    logic [EW-1:0] avsi_empty = '0;
    logic          avsi_ready;
    logic [CW-1:0] avso_one_channel, avso_two_channel;
    logic [DW-1:0] avso_one_data, avso_two_data;
    logic          avso_one_sop, avso_one_eop, avso_two_sop, avso_two_eop;
    logic [EW-1:0] avso_one_empty, avso_two_empty;
    logic          avso_one_valid, avso_two_valid;
    logic          avso_one_ready = 1'b1;
    logic          avso_two_ready = 1'b1;
`ifdef DEMUX_PKT_CNT_EN
    logic [15:0]   pkt_cnt_one, pkt_cnt_two, drop_cnt;
`endif

    always #5 clk = ~clk;

    avalon_st_demultiplexer #(
        .data_width(DW),
        .empty_width(EW),
        .channel_width(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .avsi_channel(avsi_channel),
        .avsi_data(avsi_data),
        .avsi_valid(avsi_valid),
        .avsi_sop(avsi_sop),
        .avsi_eop(avsi_eop),
        .avsi_empty(avsi_empty),
        .avsi_ready(avsi_ready),
        .avso_one_channel(avso_one_channel),
        .avso_one_data(avso_one_data),
        .avso_one_sop(avso_one_sop),
        .avso_one_eop(avso_one_eop),
        .avso_one_empty(avso_one_empty),
        .avso_one_valid(avso_one_valid),
        .avso_one_ready(avso_one_ready),
        .avso_two_channel(avso_two_channel),
        .avso_two_data(avso_two_data),
        .avso_two_sop(avso_two_sop),
        .avso_two_eop(avso_two_eop),
        .avso_two_empty(avso_two_empty),
        .avso_two_valid(avso_two_valid),
        .avso_two_ready(avso_two_ready)
`ifdef DEMUX_PKT_CNT_EN
        ,
        .pkt_cnt_one(pkt_cnt_one),
        .pkt_cnt_two(pkt_cnt_two),
        .drop_cnt(drop_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Packet-level view: are we inside a packet, and which output owns it.
    bit          in_pkt;
    int          dest;
    bit          m_v1, m_v2;
    beat_t       m_b1, m_b2;
    logic [15:0] m_pc1, m_pc2, m_drop;
    bit          m_acc;
    int          m_to;
    beat_t       m_in;

    function automatic bit model_ready();
        bit f1, f2;
        f1 = !m_v1 || avso_one_ready;
        f2 = !m_v2 || avso_two_ready;
        if (reset) return 1'b0;
        if (!in_pkt) return f1 && f2;
        return (dest == 1) ? f1 : f2;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            in_pkt = 0; dest = 1;
            m_v1 = 0; m_v2 = 0; m_b1 = '0; m_b2 = '0;
            m_pc1 = 0; m_pc2 = 0; m_drop = 0;
        end else begin
            m_in  = '{avsi_channel, avsi_data, avsi_sop, avsi_eop, avsi_empty};
            m_acc = avsi_valid && model_ready();
            m_to  = 0;
            if (m_acc) begin
                if (!in_pkt) begin
                    if (avsi_sop) begin
                        m_to = (avsi_channel == 0) ? 1 : 2;
                        if (!avsi_eop) begin in_pkt = 1; dest = m_to; end
                    end else begin
                        m_drop = m_drop + 16'd1;
                    end
                end else begin
                    m_to = dest;
                    if (avsi_eop) in_pkt = 0;
                end
            end
            if (m_v1 && avso_one_ready && m_b1.eop) m_pc1 = m_pc1 + 16'd1;
            if (m_v2 && avso_two_ready && m_b2.eop) m_pc2 = m_pc2 + 16'd1;
            if (m_to == 1) begin m_b1 = m_in; m_v1 = 1; end
            else if (avso_one_ready) m_v1 = 0;
            if (m_to == 2) begin m_b2 = m_in; m_v2 = 1; end
            else if (avso_two_ready) m_v2 = 0;
        end
    end

    // ---------------- per-cycle compare + transfer log ----------------
    logic [DW-1:0] obs_one[$];
    logic [DW-1:0] obs_two[$];
    logic [3:0]    obs_one_flags[$];
    bit            seen_two;

    always @(negedge clk) begin
        beat_t d1, d2;
        d1 = '{avso_one_channel, avso_one_data, avso_one_sop, avso_one_eop, avso_one_empty};
        d2 = '{avso_two_channel, avso_two_data, avso_two_sop, avso_two_eop, avso_two_empty};
        chk("ready", {191'd0, avsi_ready}, {191'd0, model_ready()});
        chk("valid_one", {191'd0, avso_one_valid}, {191'd0, m_v1});
        chk("valid_two", {191'd0, avso_two_valid}, {191'd0, m_v2});
        chk("beat_one", {59'd0, d1}, {59'd0, m_b1});
        chk("beat_two", {59'd0, d2}, {59'd0, m_b2});
`ifdef DEMUX_PKT_CNT_EN
        chk("cnts", {144'd0, pkt_cnt_one, pkt_cnt_two, drop_cnt}, {144'd0, m_pc1, m_pc2, m_drop});
`endif
        if (avso_one_valid && avso_one_ready) begin
            obs_one.push_back(avso_one_data);
            obs_one_flags.push_back({avso_one_sop, avso_one_eop, avso_one_empty});
        end
        if (avso_two_valid) seen_two = 1;
        if (avso_two_valid && avso_two_ready) obs_two.push_back(avso_two_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic s, input logic e, input logic [CW-1:0] ch,
                        input logic [DW-1:0] d, input logic [EW-1:0] em, output int cyc);
        bit acc;
        avsi_valid = 1; avsi_sop = s; avsi_eop = e;
        avsi_channel = ch; avsi_data = d; avsi_empty = em;
        acc = 0; cyc = 0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = avsi_ready;
            @(posedge clk); #1;
            cyc++;
        end
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
        avsi_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1;
        idle(2);
        reset = 0;
        idle(1);
    endtask

    int cyc;
    int total_cyc;

    initial begin
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("reset_ready", {191'd0, avsi_ready}, 192'd0);
        chk("reset_one", {62'd0, avso_one_valid, avso_one_channel, avso_one_data, avso_one_sop, avso_one_eop, avso_one_empty}, 192'd0);
        chk("reset_two", {62'd0, avso_two_valid, avso_two_channel, avso_two_data, avso_two_sop, avso_two_eop, avso_two_empty}, 192'd0);
        @(posedge clk); #1;
        reset = 0;
        idle(1);

        // 4-beat packet on channel 0
        obs_one.delete(); obs_one_flags.delete(); seen_two = 0;
        send(1, 0, 0, 128'h11, 0, cyc);
        send(0, 0, 0, 128'h12, 0, cyc);
        send(0, 0, 0, 128'h13, 0, cyc);
        send(0, 1, 0, 128'h14, 2, cyc);
        idle(3);
        chk("t1_count", 192'(obs_one.size()), 192'd4);
        for (int i = 0; i < 4 && i < obs_one.size(); i++)
            chk("t1_data", 192'(obs_one[i]), 192'(8'h11 + i));
        if (obs_one_flags.size() == 4) begin
            chk("t1_first_flags", 192'(obs_one_flags[0]), 192'b1000);
            chk("t1_last_flags", 192'(obs_one_flags[3]), 192'b0110);
        end
        chk("t1_two_quiet", {191'd0, seen_two}, 192'd0);

        // alternating single-beat packets, no bubbles
        obs_one.delete(); obs_two.delete();
        total_cyc = 0;
        send(1, 1, 0, 128'hA0, 0, cyc); total_cyc += cyc;
        send(1, 1, 1, 128'hB0, 0, cyc); total_cyc += cyc;
        send(1, 1, 0, 128'hA1, 0, cyc); total_cyc += cyc;
        chk("t2_no_bubble", 192'(total_cyc), 192'd3);
        idle(2);
        chk("t2_one", {obs_one.size() == 2 ? obs_one[0][7:0] : 8'h0, obs_one.size() == 2 ? obs_one[1][7:0] : 8'h0}, 192'hA0A1);
        chk("t2_two", 192'(obs_two.size() == 1 ? obs_two[0][7:0] : 8'h0), 192'hB0);

        // backpressure on output two mid-packet
        obs_two.delete();
        send(1, 0, 1, 128'h31, 0, cyc);
        send(0, 0, 1, 128'h32, 0, cyc);
        avsi_valid = 1; avsi_sop = 0; avsi_eop = 0; avsi_data = 128'h33;
        avso_two_ready = 0;
        for (int i = 0; i < 3; i++) begin
            avso_one_ready = i[0];
            @(negedge clk);
            chk("t3_stall_ready", {191'd0, avsi_ready}, 192'd0);
            @(posedge clk); #1;
        end
        avso_two_ready = 1; avso_one_ready = 1;
        send(0, 0, 1, 128'h33, 0, cyc);
        send(0, 1, 1, 128'h34, 1, cyc);
        idle(2);
        chk("t3_count", 192'(obs_two.size()), 192'd4);
        for (int i = 0; i < 4 && i < obs_two.size(); i++)
            chk("t3_data", 192'(obs_two[i]), 192'(8'h31 + i));

        // beats without sop in IDLE are dropped
        do_reset();
        obs_two.delete();
        send(0, 0, 1, 128'h55, 0, cyc);
        send(0, 0, 1, 128'h56, 0, cyc);
        send(1, 0, 1, 128'h61, 0, cyc);
        send(0, 0, 1, 128'h62, 0, cyc);
        send(0, 1, 1, 128'h63, 3, cyc);
        idle(2);
        chk("t4_count", 192'(obs_two.size()), 192'd3);
        for (int i = 0; i < 3 && i < obs_two.size(); i++)
            chk("t4_data", 192'(obs_two[i]), 192'(8'h61 + i));
`ifdef DEMUX_PKT_CNT_EN
        chk("t4_drop_cnt", 192'(drop_cnt), 192'd2);
`endif

        // reset in the middle of a packet
        obs_one.delete();
        send(1, 0, 0, 128'h71, 0, cyc);
        send(0, 0, 0, 128'h72, 0, cyc);
        reset = 1;
        #1;
        chk("t5_reset_valids", {190'd0, avso_one_valid, avso_two_valid}, 192'd0);
        idle(2);
        reset = 0;
        idle(1);
        obs_one.delete();
        send(0, 0, 0, 128'h73, 0, cyc);
        send(0, 0, 0, 128'h74, 0, cyc);
        send(0, 1, 0, 128'h75, 0, cyc);
        send(1, 1, 0, 128'h81, 1, cyc);
        idle(2);
        chk("t5_after", 192'(obs_one.size() == 1 ? obs_one[0] : 128'h0), 192'h81);

        // randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            avsi_valid   = ($urandom_range(0, 9) < 7);
            avsi_sop     = ($urandom_range(0, 9) < 3);
            avsi_eop     = ($urandom_range(0, 9) < 3);
            avsi_channel = CW'($urandom_range(0, 1));
            avsi_data    = {$urandom, $urandom, $urandom, $urandom};
            avsi_empty   = EW'($urandom_range(0, 3));
            avso_one_ready = ($urandom_range(0, 3) != 0);
            avso_two_ready = ($urandom_range(0, 3) != 0);
            if (i % 500 == 250) begin
                reset = 1; #2; reset = 0;
            end
            @(posedge clk); #1;
        end
        avsi_valid = 0; avso_one_ready = 1; avso_two_ready = 1;
        idle(3);

`ifdef DEMUX_PKT_CNT_EN
        // counter wrap: 65537 single-beat packets to output one
        do_reset();
        avsi_valid = 1; avsi_sop = 1; avsi_eop = 1; avsi_channel = 0; avsi_data = 128'h5;
        for (int i = 0; i < 65537; i++) begin @(posedge clk); #1; end
        avsi_valid = 0;
        idle(1);
        chk("wrap_one", 192'(pkt_cnt_one), 192'd1);
        chk("wrap_two", 192'(pkt_cnt_two), 192'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
